cobra_step_ctrl: RTL

Execution controller for the CYBERcobra core on the Nexys board. It turns a raw push-button and the run switch into single-cycle advance enables (`core_en_o`) for the core. It supports single-step and free-run at a fixed divided rate, and halts automatically when the core output matches a breakpoint value. It sits between the board I/O and the core's clock-enable, in the same `clk_i` domain as the seven-segment driver.

---
 rtl/cobra_ctrl_pkg.sv | 30 +++
 rtl/cobra_debounce.sv | 74 +++++++
 rtl/cobra_step_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cobra_ctrl_pkg.sv
// Purpose: shared types and defaults for the CYBERcobra execution controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ctrl_state_t        - controller FSM state
//   DEBOUNCE_CYCLES_DEF - default debounce length (10 ms at 100 MHz)
//   RUN_DIV_DEF         - default free-run divider (10 pulses/s at 100 MHz)
//   bp_match()          - breakpoint compare helper
package cobra_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    HALT  = 3'd4
  } ctrl_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned RUN_DIV_DEF         = 10_000_000;

  // Breakpoint hits only when armed and the core output equals the target.
  function automatic logic bp_match(input logic        en,
                                    input logic [31:0] core_out,
                                    input logic [31:0] bp_value);
    return en && (core_out == bp_value);
  endfunction

endpackage

// File: rtl/cobra_debounce.sv
// Purpose: 2-flop synchroniser + level debouncer + rising-edge pulse for one raw input.
// Latency: raw edge to level_o/rise_o is 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running, the input is sampled every cycle.
//
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   raw_i   - raw board input, asynchronous to clk_i
//   level_o - debounced level (registered)
//   rise_o  - one-cycle pulse in the first cycle level_o is high (registered)
module cobra_debounce
  import cobra_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  // The counter only has to reach DEBOUNCE_CYCLES-1: the sample that would
  // make it DEBOUNCE_CYCLES is the one that flips the level.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // sync_q[1] is the metastability-safe sample; sync_q[0] is never used
  // outside the synchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Any sample matching the current level restarts the run of differing
  // samples, so only an uninterrupted run can change the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign rise_d = level_d & ~level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/cobra_step_ctrl.sv
// Purpose: turns step button / run switch into single-cycle core advance enables, with breakpoint halt.
// Latency: press -> core_en_o next cycle; RUN entry -> first pulse after RUN_DIV-1 cycles, then every RUN_DIV+1.
// Backpressure: none; the core always accepts core_en_o, presses during RUN/HALT/STEP/CHECK are dropped.
//
// Ports:
//   clk_i       - 100 MHz system clock
//   rst_i       - asynchronous active-high reset
//   btn_step_i  - raw step push-button (asynchronous)
//   run_i       - raw run switch (asynchronous)
//   bp_en_i     - breakpoint enable (quasi-static)
//   bp_value_i  - breakpoint compare value
//   core_out_i  - core out_o, compared in CHECK only
//   core_en_o   - one-cycle advance enable to the core
//   halted_o    - high while stopped on a breakpoint
//   running_o   - high while free-running
//   step_cnt_o  - core_en_o pulses issued since reset (wraps)
module cobra_step_ctrl
  import cobra_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RUN_DIV         = RUN_DIV_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_step_i,
  input  logic        run_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_value_i,
  input  logic [31:0] core_out_i,
  output logic        core_en_o,
  output logic        halted_o,
  output logic        running_o,
  output logic [31:0] step_cnt_o
);

  localparam int unsigned DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic press;
  logic btn_lvl_unused;
  logic run_lvl;
  logic run_rise_unused;

  cobra_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (btn_step_i),
    .level_o (btn_lvl_unused),
    .rise_o  (press)
  );

  cobra_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (run_i),
    .level_o (run_lvl),
    .rise_o  (run_rise_unused)
  );

  // ---------------------------------------------------------------------------
  // FSM, run divider, pulse decode
  // ---------------------------------------------------------------------------
  ctrl_state_t   state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          core_en;
  logic          bp_hit;

  assign bp_hit = bp_match(bp_en_i, core_out_i, bp_value_i);

  always_comb begin
    state_d = state_q;
    core_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A press beats a simultaneous run qualification.
        if (press) begin
          state_d = STEP;
        end else if (run_lvl) begin
          state_d = RUN;
        end
      end
      STEP: begin
        core_en = 1'b1;
        state_d = CHECK;
      end
      RUN: begin
        // Switch-off wins over a terminal count landing in the same cycle,
        // so the pulse is suppressed as well as the transition.
        if (!run_lvl) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          core_en = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // core_out_i has had a full cycle to settle after the pulse.
        if (bp_hit) begin
          state_d = HALT;
        end else if (run_lvl) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (!run_lvl) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The divider only advances while staying in RUN; every entry into RUN
  // (from IDLE or CHECK) therefore starts at zero.
  always_comb begin
    div_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Step counter
  // ---------------------------------------------------------------------------
  logic [31:0] step_cnt_q;
  logic [31:0] step_cnt_d;

  assign step_cnt_d = step_cnt_q + {31'd0, core_en};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded purely from flops (state, divider, debounced run level),
  // never from raw inputs, so they are glitch-free at the core boundary.
  // ---------------------------------------------------------------------------
  assign core_en_o  = core_en;
  assign halted_o   = (state_q == HALT);
  assign running_o  = (state_q == RUN);
  assign step_cnt_o = step_cnt_q;

endmodule
